// File: rtl/fir_pkg.sv
// Shared widths, coefficient set and output rounding/saturation helper for the
// 16-tap symmetric low-pass FIR.
package fir_pkg;

    localparam int unsigned IN_W   = 14;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned PROD_W = 30;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned NTAPS  = 16;

    // Q1.15 taps, symmetric, summing to 32768 for unity DC gain
    localparam logic signed [COEF_W-1:0] COEFS [0:NTAPS-1] = '{
        -16'sd128,  -16'sd256,  16'sd0,     16'sd1024,
         16'sd2560,  16'sd3840, 16'sd4480,  16'sd4864,
         16'sd4864,  16'sd4480, 16'sd3840,  16'sd2560,
         16'sd1024,  16'sd0,    -16'sd256,  -16'sd128
    };

    localparam logic signed [ACC_W-1:0] ROUND_BIAS  = 32'sd16384;
    localparam int unsigned             ROUND_SHIFT = 15;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Round half toward +inf back to Q1.13, then clamp to the output range
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        biased  = acc + ROUND_BIAS;
        shifted = biased >>> ROUND_SHIFT;
        if (shifted > ACC_W'(OUT_MAX)) begin
            return OUT_MAX;
        end else if (shifted < ACC_W'(OUT_MIN)) begin
            return OUT_MIN;
        end
        return OUT_W'(shifted);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Four-level registered binary adder tree (16 -> 1), full precision, latency 4.
module fir_adder_tree
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic [NTAPS*PROD_W-1:0]   prods_i,
    output logic signed [ACC_W-1:0]   sum_o
);

    logic signed [PROD_W-1:0] prod_s [0:NTAPS-1];
    logic signed [ACC_W-1:0]  l1_d [0:7];
    logic signed [ACC_W-1:0]  l1_q [0:7];
    logic signed [ACC_W-1:0]  l2_d [0:3];
    logic signed [ACC_W-1:0]  l2_q [0:3];
    logic signed [ACC_W-1:0]  l3_d [0:1];
    logic signed [ACC_W-1:0]  l3_q [0:1];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;

    always_comb begin
        for (int i = 0; i < int'(NTAPS); i++) begin
            prod_s[i] = prods_i[i*PROD_W +: PROD_W];
        end
        for (int i = 0; i < 8; i++) begin
            l1_d[i] = ACC_W'(prod_s[2*i]) + ACC_W'(prod_s[2*i+1]);
        end
        for (int i = 0; i < 4; i++) begin
            l2_d[i] = l1_q[2*i] + l1_q[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            l3_d[i] = l2_q[2*i] + l2_q[2*i+1];
        end
        sum_d = l3_q[0] + l3_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) l1_q[i] <= '0;
            for (int i = 0; i < 4; i++) l2_q[i] <= '0;
            for (int i = 0; i < 2; i++) l3_q[i] <= '0;
            sum_q <= '0;
        end else if (en_i) begin
            for (int i = 0; i < 8; i++) l1_q[i] <= l1_d[i];
            for (int i = 0; i < 4; i++) l2_q[i] <= l2_d[i];
            for (int i = 0; i < 2; i++) l3_q[i] <= l3_d[i];
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/fir_filter.sv
// 16-tap symmetric low-pass FIR, direct form, 7-stage pipeline gated by clk_enable.
module fir_filter
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic signed [IN_W-1:0]   filter_in,
    output logic signed [OUT_W-1:0]  filter_out
);

    logic signed [IN_W-1:0]   taps_d [0:NTAPS-1];
    logic signed [IN_W-1:0]   taps_q [0:NTAPS-1];
    logic signed [PROD_W-1:0] prod_d [0:NTAPS-1];
    logic signed [PROD_W-1:0] prod_q [0:NTAPS-1];
    logic [NTAPS*PROD_W-1:0]  prods_flat;
    logic signed [ACC_W-1:0]  sum;
    logic signed [OUT_W-1:0]  out_d;
    logic signed [OUT_W-1:0]  out_q;

    // Delay line shift and per-tap products; 14x16 products always fit in 30 bits
    always_comb begin
        taps_d[0] = filter_in;
        for (int k = 1; k < int'(NTAPS); k++) begin
            taps_d[k] = taps_q[k-1];
        end
        for (int k = 0; k < int'(NTAPS); k++) begin
            prod_d[k] = PROD_W'(taps_q[k]) * PROD_W'(COEFS[k]);
        end
        prods_flat = '0;
        for (int k = 0; k < int'(NTAPS); k++) begin
            prods_flat[k*PROD_W +: PROD_W] = prod_q[k];
        end
        out_d = round_sat(sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                taps_q[k] <= '0;
                prod_q[k] <= '0;
            end
            out_q <= '0;
        end else if (clk_enable) begin
            for (int k = 0; k < int'(NTAPS); k++) begin
                taps_q[k] <= taps_d[k];
                prod_q[k] <= prod_d[k];
            end
            out_q <= out_d;
        end
    end

    fir_adder_tree u_tree (
        .clk     (clk),
        .reset   (reset),
        .en_i    (clk_enable),
        .prods_i (prods_flat),
        .sum_o   (sum)
    );

    assign filter_out = out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed self-checking bench for fir_filter: reset, step, impulse, saturation,
// enable gating and mid-run reset.
module tb_fir_filter;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               clk_enable = 1'b0;
    logic signed [13:0] filter_in = '0;
    logic signed [13:0] filter_out;

    int checks = 0;
    int failures = 0;

    // Hand-computed: round(7373 * cumsum(c) / 32768), half toward +inf
    int step_exp [0:15] = '{-29, -86, -86, 144, 720, 1584, 2592, 3687,
                            4781, 5789, 6653, 7229, 7459, 7459, 7402, 7373};
    // Hand-computed: round(8191 * c[k] / 32768)
    int imp_exp [0:15]  = '{-32, -64, 0, 256, 640, 960, 1120, 1216,
                            1216, 1120, 960, 640, 256, 0, -64, -32};
    // Worst-case positive window: +max where c>0, -max where c<0
    int sat_win [0:15]  = '{-8192, -8192, 0, 8191, 8191, 8191, 8191, 8191,
                            8191, 8191, 8191, 8191, 8191, 0, -8192, -8192};

    fir_filter dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .filter_in  (filter_in),
        .filter_out (filter_out)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs, let the edge happen, settle before sampling
    task automatic tick(input logic r, input logic en, input int x);
        reset      = r;
        clk_enable = en;
        filter_in  = 14'(x);
        @(posedge clk);
        #1;
    endtask

    function automatic int step_at(input int i);
        if (i < 6)  return 0;
        if (i < 22) return step_exp[i-6];
        return 7373;
    endfunction

    task automatic test_reset();
        logic signed [13:0] expv;
        expv = '0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, int'($urandom_range(0, 16383)) - 8192);
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL reset_hold[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 0);
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL reset_fill[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
    endtask

    task automatic test_step();
        logic signed [13:0] expv;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b1, 7373);
            expv = 14'(step_at(i));
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL step[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
    endtask

    task automatic test_impulse();
        logic signed [13:0] expv;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b1, (i == 0) ? 8191 : 0);
            if (i < 6 || i >= 22) expv = '0;
            else                  expv = 14'(imp_exp[i-6]);
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL impulse[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [13:0] expv;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 22; i++) begin
            tick(1'b0, 1'b1, (i < 16) ? sat_win[i] : 0);
        end
        expv = 14'sd8191;
        checks++;
        if (filter_out !== expv) begin
            failures++;
            $display("FAIL sat_pos got=%0d exp=%0d", filter_out, expv);
        end
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 22; i++) begin
            tick(1'b0, 1'b1, -8192);
        end
        expv = 14'h2000;
        checks++;
        if (filter_out !== expv) begin
            failures++;
            $display("FAIL sat_neg got=%0d exp=%0d", filter_out, expv);
        end
    endtask

    task automatic test_enable_gating();
        logic signed [13:0] expv;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b1, 7373);
            expv = 14'(step_at(i));
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL gate_pre[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
        expv = 14'(step_at(8));
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, int'($urandom_range(0, 16383)) - 8192);
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL gate_hold[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
        for (int i = 9; i < 24; i++) begin
            tick(1'b0, 1'b1, 7373);
            expv = 14'(step_at(i));
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL gate_post[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic signed [13:0] expv;
        tick(1'b1, 1'b1, 0);
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b1, 7373);
        expv = 14'sd7373;
        checks++;
        if (filter_out !== expv) begin
            failures++;
            $display("FAIL midrst_steady got=%0d exp=%0d", filter_out, expv);
        end
        tick(1'b1, 1'b1, 7373);
        expv = '0;
        checks++;
        if (filter_out !== expv) begin
            failures++;
            $display("FAIL midrst_clear got=%0d exp=%0d", filter_out, expv);
        end
        for (int i = 0; i < 24; i++) begin
            tick(1'b0, 1'b1, 7373);
            expv = 14'(step_at(i));
            checks++;
            if (filter_out !== expv) begin
                failures++;
                $display("FAIL midrst_step[%0d] got=%0d exp=%0d", i, filter_out, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_impulse();
        test_saturation();
        test_enable_gating();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
